// File: rtl/domain_slot_scheduler_if.sv
// Handshake bundle between the two domain sources, the scheduler and the downstream mux.
interface domain_slot_scheduler_if #(
    parameter int unsigned DATA_W = 8
);
    logic              d1_valid;
    logic [DATA_W-1:0] d1_data;
    logic              d1_ready;
    logic              d2_valid;
    logic [DATA_W-1:0] d2_data;
    logic              d2_ready;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              sel;
    logic              scrub;
    logic              drop_d1;
    logic              drop_d2;

    // Environment side: drives sources and downstream ready
    modport master (
        output d1_valid, d1_data, d2_valid, d2_data, out_ready,
        input  d1_ready, d2_ready, out_valid, out_data, sel, scrub, drop_d1, drop_d2
    );

    // Scheduler side
    modport slave (
        input  d1_valid, d1_data, d2_valid, d2_data, out_ready,
        output d1_ready, d2_ready, out_valid, out_data, sel, scrub, drop_d1, drop_d2
    );
endinterface

// File: rtl/domain_slot_scheduler.sv
// Fixed time-division scheduler: one domain per slot, one-entry output register,
// register scrubbed between slots so nothing of one domain leaks into the other's slot.
module domain_slot_scheduler #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned SLOT_LEN  = 16,
    parameter int unsigned SCRUB_LEN = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    domain_slot_scheduler_if.slave  bus
);

    localparam int unsigned LEN_MAX = (SLOT_LEN > SCRUB_LEN) ? SLOT_LEN : SCRUB_LEN;
    localparam int unsigned CNT_W   = $clog2(LEN_MAX);

    typedef enum logic [1:0] {
        SLOT_D1 = 2'd0,
        SCRUB_1 = 2'd1,
        SLOT_D2 = 2'd2,
        SCRUB_2 = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ov_q, ov_d;
    logic [DATA_W-1:0]   od_q, od_d;
    logic                sel_q, sel_d;
    logic                scrub_q, scrub_d;
    logic                drop1_q, drop1_d;
    logic                drop2_q, drop2_d;
    logic                d1_ready_c, d2_ready_c;
    logic                room_c;
    logic                slot_last_c;
    logic                scrub_last_c;
    logic                load_c;
    logic [DATA_W-1:0]   load_data_c;

    // State, slot counter and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_D1;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            sel_q   <= 1'b0;
            scrub_q <= 1'b0;
            drop1_q <= 1'b0;
            drop2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            sel_q   <= sel_d;
            scrub_q <= scrub_d;
            drop1_q <= drop1_d;
            drop2_q <= drop2_d;
        end
    end

    // Schedule sequencing, acceptance and output register next values
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        ov_d         = ov_q;
        od_d         = od_q;
        drop1_d      = 1'b0;
        drop2_d      = 1'b0;
        d1_ready_c   = 1'b0;
        d2_ready_c   = 1'b0;
        room_c       = !ov_q || bus.out_ready;
        slot_last_c  = (cnt_q == CNT_W'(SLOT_LEN - 1));
        scrub_last_c = (cnt_q == CNT_W'(SCRUB_LEN - 1));

        case (state_q)
            SLOT_D1: begin
                // rst_n term keeps ready low while reset is held
                d1_ready_c = rst_n && (cnt_q < CNT_W'(SLOT_LEN - 1)) && room_c;
                if (slot_last_c) begin
                    state_d = SCRUB_1;
                    cnt_d   = '0;
                    drop1_d = ov_q && !bus.out_ready;
                end
            end
            SCRUB_1: begin
                if (scrub_last_c) begin
                    state_d = SLOT_D2;
                    cnt_d   = '0;
                end
            end
            SLOT_D2: begin
                d2_ready_c = rst_n && (cnt_q < CNT_W'(SLOT_LEN - 1)) && room_c;
                if (slot_last_c) begin
                    state_d = SCRUB_2;
                    cnt_d   = '0;
                    drop2_d = ov_q && !bus.out_ready;
                end
            end
            SCRUB_2: begin
                if (scrub_last_c) begin
                    state_d = SLOT_D1;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = SLOT_D1;
                cnt_d   = '0;
            end
        endcase

        load_c      = (d1_ready_c && bus.d1_valid) || (d2_ready_c && bus.d2_valid);
        load_data_c = d1_ready_c ? bus.d1_data : bus.d2_data;

        if (load_c) begin
            ov_d = 1'b1;
            od_d = load_data_c;
        end else if (ov_q && bus.out_ready) begin
            ov_d = 1'b0;
        end

        // Entering or staying in scrub empties the register (discarding an undelivered word)
        if (state_d == SCRUB_1 || state_d == SCRUB_2) begin
            ov_d = 1'b0;
        end
        if (!ov_d) begin
            od_d = '0;
        end

        sel_d   = (state_d == SLOT_D2) || (state_d == SCRUB_2);
        scrub_d = (state_d == SCRUB_1) || (state_d == SCRUB_2);
    end

    assign bus.d1_ready  = d1_ready_c;
    assign bus.d2_ready  = d2_ready_c;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bus.sel       = sel_q;
    assign bus.scrub     = scrub_q;
    assign bus.drop_d1   = drop1_q;
    assign bus.drop_d2   = drop2_q;

endmodule

// File: tb/tb_domain_slot_scheduler.sv
// Bench for domain_slot_scheduler: vector table, directed corner sequences and
// randomized traffic checked every cycle against a queue-based schedule model.
module tb_domain_slot_scheduler;

    localparam int unsigned DW = 8;
    localparam int unsigned S  = 16;
    localparam int unsigned C  = 2;
    localparam int unsigned P  = 2 * (S + C);

    logic clk = 1'b0;
    logic rst_n;

    domain_slot_scheduler_if #(.DATA_W(DW)) bus ();

    domain_slot_scheduler #(
        .DATA_W   (DW),
        .SLOT_LEN (S),
        .SCRUB_LEN(C)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: cycle count since reset, queue of accepted-but-undelivered words
    int unsigned     m_t;
    logic [DW-1:0]   m_q[$];
    logic            m_drop1, m_drop2;

    // Outputs observed in the most recent cycle
    logic            o_sel, o_scrub, o_ov, o_r1, o_r2, o_dr1, o_dr2;
    logic [DW-1:0]   o_od;

    typedef struct {
        logic          d1v;
        logic [DW-1:0] d1d;
        logic          d2v;
        logic [DW-1:0] d2d;
        logic          ordy;
        logic          e_sel;
        logic          e_scrub;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic          e_r1;
        logic          e_r2;
        logic          e_dr1;
        logic          e_dr2;
    } vec_t;

    vec_t tbl[P + 2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_t = 0;
        m_q.delete();
        m_drop1 = 1'b0;
        m_drop2 = 1'b0;
    endtask

    // Compare DUT against the model for the current cycle, then advance the model
    task automatic model_cycle();
        int unsigned ph, pos;
        logic dom, inslot, room, e_ov, e_r1, e_r2, nd1, nd2;
        logic [DW-1:0] e_od;
        ph     = m_t % P;
        dom    = (ph >= S + C);
        pos    = ph % (S + C);
        inslot = (pos < S);
        e_ov   = (m_q.size() != 0);
        e_od   = e_ov ? m_q[0] : '0;
        room   = !e_ov || bus.out_ready;
        e_r1   = inslot && !dom && (pos < S - 1) && room;
        e_r2   = inslot &&  dom && (pos < S - 1) && room;
        chk("model_sel",       32'(o_sel),   32'(dom));
        chk("model_scrub",     32'(o_scrub), 32'(!inslot));
        chk("model_out_valid", 32'(o_ov),    32'(e_ov));
        chk("model_out_data",  32'(o_od),    32'(e_od));
        chk("model_d1_ready",  32'(o_r1),    32'(e_r1));
        chk("model_d2_ready",  32'(o_r2),    32'(e_r2));
        chk("model_drop_d1",   32'(o_dr1),   32'(m_drop1));
        chk("model_drop_d2",   32'(o_dr2),   32'(m_drop2));
        nd1 = 1'b0;
        nd2 = 1'b0;
        if (e_ov && bus.out_ready) void'(m_q.pop_front());
        if (e_r1 && bus.d1_valid) m_q.push_back(bus.d1_data);
        if (e_r2 && bus.d2_valid) m_q.push_back(bus.d2_data);
        if (inslot && pos == S - 1 && m_q.size() != 0) begin
            if (dom) nd2 = 1'b1;
            else     nd1 = 1'b1;
            m_q.delete();
        end
        m_drop1 = nd1;
        m_drop2 = nd2;
        m_t++;
    endtask

    // One clock cycle: inputs already applied; sample on the falling edge
    task automatic step();
        @(negedge clk);
        o_sel   = bus.sel;
        o_scrub = bus.scrub;
        o_ov    = bus.out_valid;
        o_od    = bus.out_data;
        o_r1    = bus.d1_ready;
        o_r2    = bus.d2_ready;
        o_dr1   = bus.drop_d1;
        o_dr2   = bus.drop_d2;
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_in(input logic d1v, input logic [DW-1:0] d1d,
                          input logic d2v, input logic [DW-1:0] d2d, input logic ordy);
        bus.d1_valid  = d1v;
        bus.d1_data   = d1d;
        bus.d2_valid  = d2v;
        bus.d2_data   = d2d;
        bus.out_ready = ordy;
    endtask

    // Hold reset across one edge, verify reset values, release so cycle 0 begins
    task automatic reset_dut();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_sel",       32'(bus.sel),       32'd0);
        chk("rst_scrub",     32'(bus.scrub),     32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_d1_ready",  32'(bus.d1_ready),  32'd0);
        chk("rst_d2_ready",  32'(bus.d2_ready),  32'd0);
        chk("rst_drop_d1",   32'(bus.drop_d1),   32'd0);
        chk("rst_drop_d2",   32'(bus.drop_d2),   32'd0);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // Idle run: fixed schedule, nothing ever presented
    task automatic idle_schedule(input int n);
        for (int c = 0; c < n; c++) begin
            int ph;
            set_in(1'b0, '0, 1'b0, '0, 1'b1);
            step();
            ph = c % int'(P);
            chk("idle_sel",   32'(o_sel),   32'(ph >= 18 && ph <= 35));
            chk("idle_scrub", 32'(o_scrub), 32'(ph == 16 || ph == 17 || ph == 34 || ph == 35));
            chk("idle_out_valid", 32'(o_ov), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, '0, 1'b0, '0, 1'b0);

        // Vector table: D1 streaming 0,1,2.. and D2 holding 0xA5, downstream always ready
        for (int c = 0; c < int'(P) + 2; c++) begin
            tbl[c].d1v     = 1'b1;
            tbl[c].d1d     = DW'(c);
            tbl[c].d2v     = 1'b1;
            tbl[c].d2d     = 8'hA5;
            tbl[c].ordy    = 1'b1;
            tbl[c].e_sel   = (c >= 18 && c <= 35);
            tbl[c].e_scrub = (c == 16 || c == 17 || c == 34 || c == 35);
            tbl[c].e_r1    = (c <= 14 || c >= 36);
            tbl[c].e_r2    = (c >= 18 && c <= 32);
            tbl[c].e_ov    = (c >= 1 && c <= 15) || (c >= 19 && c <= 33) || (c == 37);
            if (c >= 1 && c <= 15)       tbl[c].e_od = DW'(c - 1);
            else if (c >= 19 && c <= 33) tbl[c].e_od = 8'hA5;
            else if (c == 37)            tbl[c].e_od = DW'(36);
            else                         tbl[c].e_od = '0;
            tbl[c].e_dr1   = 1'b0;
            tbl[c].e_dr2   = 1'b0;
        end

        // Idle schedule after reset
        reset_dut();
        idle_schedule(int'(P) + 2);

        // Table-driven full-throughput period
        reset_dut();
        for (int c = 0; c < int'(P) + 2; c++) begin
            set_in(tbl[c].d1v, tbl[c].d1d, tbl[c].d2v, tbl[c].d2d, tbl[c].ordy);
            step();
            chk("tbl_sel",       32'(o_sel),   32'(tbl[c].e_sel));
            chk("tbl_scrub",     32'(o_scrub), 32'(tbl[c].e_scrub));
            chk("tbl_out_valid", 32'(o_ov),    32'(tbl[c].e_ov));
            chk("tbl_out_data",  32'(o_od),    32'(tbl[c].e_od));
            chk("tbl_d1_ready",  32'(o_r1),    32'(tbl[c].e_r1));
            chk("tbl_d2_ready",  32'(o_r2),    32'(tbl[c].e_r2));
            chk("tbl_drop_d1",   32'(o_dr1),   32'(tbl[c].e_dr1));
            chk("tbl_drop_d2",   32'(o_dr2),   32'(tbl[c].e_dr2));
        end

        // Stalled D1 word at slot end is discarded with a drop pulse
        reset_dut();
        for (int c = 0; c < int'(P); c++) begin
            set_in(c == 10, 8'h3C, 1'b0, '0, c >= 16);
            step();
            if (c == 10) chk("drop_seq_ready", 32'(o_r1), 32'd1);
            if (c >= 11 && c <= 15) begin
                chk("drop_seq_valid", 32'(o_ov), 32'd1);
                chk("drop_seq_data",  32'(o_od), 32'h3C);
            end
            if (c == 16) begin
                chk("drop_seq_pulse", 32'(o_dr1), 32'd1);
                chk("drop_seq_clear", 32'(o_od),  32'd0);
            end
            if (c == 17) chk("drop_seq_pulse_end", 32'(o_dr1), 32'd0);
            if (c >= 18) chk("drop_seq_no_leak", 32'(o_ov), 32'd0);
        end

        // Backpressure toggling: words stay in order, none duplicated
        begin
            logic [DW-1:0] nxt, exp_del;
            int acc, del, drp;
            nxt = '0; exp_del = '0; acc = 0; del = 0; drp = 0;
            reset_dut();
            for (int c = 0; c < 18; c++) begin
                logic ordy;
                ordy = (c % 2 == 0);
                set_in(1'b1, nxt, 1'b0, '0, ordy);
                step();
                if (c <= 15)
                    chk("bp_ready_rule", 32'(o_r1), 32'(c < 15 && !(o_ov && !ordy)));
                if (o_r1) begin
                    nxt = nxt + DW'(1);
                    acc++;
                end
                if (o_ov && ordy) begin
                    chk("bp_order", 32'(o_od), 32'(exp_del));
                    exp_del = exp_del + DW'(1);
                    del++;
                end
                if (o_dr1) drp++;
            end
            chk("bp_conservation", 32'(acc), 32'(del + drp));
        end

        // Randomized traffic against the model
        reset_dut();
        for (int c = 0; c < 300; c++) begin
            set_in(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                   DW'($urandom), ($urandom_range(0, 3) != 0));
            step();
        end

        // Asynchronous reset inside the D2 slot with a word held
        reset_dut();
        for (int c = 0; c < 25; c++) begin
            set_in(1'b0, '0, 1'b1, 8'h5A, 1'b0);
            step();
            if (c >= 19) chk("arst_held", 32'(o_ov), 32'd1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_out_data",  32'(bus.out_data),  32'd0);
        chk("arst_sel",       32'(bus.sel),       32'd0);
        chk("arst_d2_ready",  32'(bus.d2_ready),  32'd0);
        chk("arst_drop_d2",   32'(bus.drop_d2),   32'd0);
        set_in(1'b0, '0, 1'b0, '0, 1'b1);
        reset_dut();
        idle_schedule(int'(P) + 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global guard against a hung run
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
